all_bit_zero_or_one_detector: RTL and testbench
===============================================

ALL_BIT_ZERO_OR_ONE_DETECTOR -- requirements
Module: all_bit_zero_or_one_detector

Interface
REQ-001 Parameter: WIDTH, 8, bit width of input word x.
REQ-002 Parameter: CNT_W, 8, width of each run counter.
REQ-003 Port: clk  input  1  single clock; all registers update on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: x  input  WIDTH  word under test.
REQ-006 Port: in_valid  input  1  x is sampled into registered outputs when high.
REQ-007 Port: zero  output  1  combinational; 1 iff every bit of x is 0.
REQ-008 Port: one  output  1  combinational; 1 iff every bit of x is 1.
REQ-009 Port: zero_q  output  1  registered zero of last valid sample.
REQ-010 Port: one_q  output  1  registered one of last valid sample.
REQ-011 Port: out_valid  output  1  pulses high the cycle after an accepted sample.
REQ-012 Port: zero_run  output  CNT_W  count of consecutive valid all-zero samples.
REQ-013 Port: one_run  output  CNT_W  count of consecutive valid all-one samples.

Function
REQ-014 zero/one SHALL depend only on current x, no clock dependence, settle within the same simulation delta chain.
REQ-015 zero and one SHALL never both be 1 for WIDTH >= 1 (x is mixed -> both 0).
REQ-016 X/Z on any bit of x: zero/one SHALL not be forced to a known value (propagate X).
REQ-017 On a rising edge with in_valid=1 and rst=0: zero_q<=zero, one_q<=one, out_valid<=1.
REQ-018 On a rising edge with in_valid=0 and rst=0: zero_q/one_q hold, out_valid<=0, run counters hold.
REQ-019 Accepted all-zero sample: zero_run increments, one_run clears to 0.
REQ-020 Accepted all-one sample: one_run increments, zero_run clears to 0.
REQ-021 Accepted mixed sample: both run counters clear to 0.
REQ-022 Run counters SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-023 Registered latency: 1 cycle from accepted sample to zero_q/one_q/out_valid.
REQ-024 Companion variant all_bit_zero_or_one_detector_reduction SHALL have identical parameters, ports and cycle behaviour, computing zero/one with reduction operators; the primary variant computes them with an explicit per-bit OR/AND chain.

Reset
REQ-025 rst=1 at a rising edge: zero_q=0, one_q=0, out_valid=0, zero_run=0, one_run=0; rst takes priority over in_valid.
REQ-026 Reset SHALL NOT affect combinational zero/one.
REQ-027 Reset asserted mid-run clears counters that edge; counting restarts from the first valid sample after rst deasserts.

Verification
REQ-028 x=8'h00 -> zero=1, one=0; x=8'hFF -> zero=0, one=1 (combinational, checked 10 ns after change, no clock needed).
REQ-029 x=8'hAA, 8'h7F, 8'hFE each -> zero=0, one=0.
REQ-030 in_valid=1, x=8'h00 for 3 edges -> zero_q=1, out_valid=1, zero_run=3, one_run=0; then x=8'hFF one edge -> one_q=1, one_run=1, zero_run=0.
REQ-031 in_valid=1, x=8'h00 for 300 edges with CNT_W=8 -> zero_run saturates at 255.
REQ-032 Mid-run rst=1 for one edge -> all registered outputs 0 next cycle; in_valid=0 afterwards -> outputs hold, out_valid=0.
REQ-033 Random x over 1000 cycles -> both variants match each other and a golden model (x==0, x=={WIDTH{1}}) bit-exactly.

Source files
------------

// File: rtl/all_bit_zero_or_one_detector.sv
// All-zero / all-one word detector with registered flags and saturating run counters.
// Primary variant uses an explicit per-bit OR/AND chain; the companion uses reduction operators.

module all_bit_zero_or_one_detector_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             zero,
  input  logic             one,
  output logic             zero_q,
  output logic             one_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] zero_run,
  output logic [CNT_W-1:0] one_run
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             zflag_q, zflag_d;
  logic             oflag_q, oflag_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] zrun_q, zrun_d;
  logic [CNT_W-1:0] orun_q, orun_d;

  always_comb begin
    zflag_d = zflag_q;
    oflag_d = oflag_q;
    valid_d = 1'b0;
    zrun_d  = zrun_q;
    orun_d  = orun_q;
    if (in_valid) begin
      zflag_d = zero;
      oflag_d = one;
      valid_d = 1'b1;
      // A run survives only while the same kind of word keeps arriving; counters stick at max.
      zrun_d  = zero ? ((zrun_q == CNT_MAX) ? zrun_q : zrun_q + 1'b1) : '0;
      orun_d  = one  ? ((orun_q == CNT_MAX) ? orun_q : orun_q + 1'b1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zflag_q <= 1'b0;
      oflag_q <= 1'b0;
      valid_q <= 1'b0;
      zrun_q  <= '0;
      orun_q  <= '0;
    end else begin
      zflag_q <= zflag_d;
      oflag_q <= oflag_d;
      valid_q <= valid_d;
      zrun_q  <= zrun_d;
      orun_q  <= orun_d;
    end
  end

  assign zero_q    = zflag_q;
  assign one_q     = oflag_q;
  assign out_valid = valid_q;
  assign zero_run  = zrun_q;
  assign one_run   = orun_q;
endmodule

module all_bit_zero_or_one_detector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic             in_valid,
  output logic             zero,
  output logic             one,
  output logic             zero_q,
  output logic             one_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] zero_run,
  output logic [CNT_W-1:0] one_run
);
  logic [WIDTH:0] or_chain;
  logic [WIDTH:0] and_chain;

  assign or_chain[0]  = 1'b0;
  assign and_chain[0] = 1'b1;

  // Plain gates keep X/Z on any bit flowing through to the flags.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    assign or_chain[gi+1]  = or_chain[gi]  | x[gi];
    assign and_chain[gi+1] = and_chain[gi] & x[gi];
  end

  assign zero = ~or_chain[WIDTH];
  assign one  = and_chain[WIDTH];

  all_bit_zero_or_one_detector_core #(.CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .zero      (zero),
    .one       (one),
    .zero_q    (zero_q),
    .one_q     (one_q),
    .out_valid (out_valid),
    .zero_run  (zero_run),
    .one_run   (one_run)
  );
endmodule

module all_bit_zero_or_one_detector_reduction #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic             in_valid,
  output logic             zero,
  output logic             one,
  output logic             zero_q,
  output logic             one_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] zero_run,
  output logic [CNT_W-1:0] one_run
);
  assign zero = ~|x;
  assign one  = &x;

  all_bit_zero_or_one_detector_core #(.CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .zero      (zero),
    .one       (one),
    .zero_q    (zero_q),
    .one_q     (one_q),
    .out_valid (out_valid),
    .zero_run  (zero_run),
    .one_run   (one_run)
  );
endmodule

// File: tb/tb_all_bit_zero_or_one_detector.sv
// Scoreboard bench: expected registered results are queued when a sample is driven
// and popped when out_valid appears; both variants are checked against a golden model.

module tb_all_bit_zero_or_one_detector;
  localparam int WIDTH   = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] x;
  logic             in_valid;
  logic             zero, one, zero_q, one_q, out_valid;
  logic [CNT_W-1:0] zero_run, one_run;
  logic             r_zero, r_one, r_zero_q, r_one_q, r_out_valid;
  logic [CNT_W-1:0] r_zero_run, r_one_run;

  always #5 clk = ~clk;

  all_bit_zero_or_one_detector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid),
    .zero(zero), .one(one), .zero_q(zero_q), .one_q(one_q),
    .out_valid(out_valid), .zero_run(zero_run), .one_run(one_run)
  );

  all_bit_zero_or_one_detector_reduction #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut_red (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid),
    .zero(r_zero), .one(r_one), .zero_q(r_zero_q), .one_q(r_one_q),
    .out_valid(r_out_valid), .zero_run(r_zero_run), .one_run(r_one_run)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Golden model of the registered state
  int   m_zrun = 0, m_orun = 0;
  logic m_zq = 1'b0, m_oq = 1'b0;
  logic [1+1+CNT_W+CNT_W-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_comb(input logic [WIDTH-1:0] xv);
    logic ez, eo;
    ez = (xv == '0);
    eo = (xv == '1);
    check("zero", {31'd0, zero}, {31'd0, ez});
    check("one", {31'd0, one}, {31'd0, eo});
    check("red_zero", {31'd0, r_zero}, {31'd0, ez});
    check("red_one", {31'd0, r_one}, {31'd0, eo});
  endtask

  task automatic cycle(input logic [WIDTH-1:0] xv, input logic v, input logic r);
    logic ev;
    logic [1+1+CNT_W+CNT_W-1:0] e, got, got_red;
    x = xv; in_valid = v; rst = r;
    if (r) begin
      m_zrun = 0; m_orun = 0; m_zq = 1'b0; m_oq = 1'b0;
      sb.delete();
    end else if (v) begin
      m_zq = (xv == '0);
      m_oq = (xv == '1);
      m_zrun = m_zq ? ((m_zrun == CNT_MAX) ? CNT_MAX : m_zrun + 1) : 0;
      m_orun = m_oq ? ((m_orun == CNT_MAX) ? CNT_MAX : m_orun + 1) : 0;
      sb.push_back({m_zq, m_oq, CNT_W'(m_zrun), CNT_W'(m_orun)});
    end
    ev = v && !r;
    @(posedge clk);
    #1;
    got     = {zero_q, one_q, zero_run, one_run};
    got_red = {r_zero_q, r_one_q, r_zero_run, r_one_run};
    check("out_valid", {31'd0, out_valid}, {31'd0, ev});
    if (out_valid) begin
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("regs", {14'd0, got}, {14'd0, e});
      end
    end else begin
      if (ev && sb.size() != 0) void'(sb.pop_front());
      check("hold", {14'd0, got}, {14'd0, m_zq, m_oq, CNT_W'(m_zrun), CNT_W'(m_orun)});
    end
    check("variant", {13'd0, r_out_valid, got_red}, {13'd0, out_valid, got});
  endtask

  initial begin
    logic [WIDTH-1:0] vals [5];
    logic [WIDTH-1:0] xr;
    vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'hAA; vals[3] = 8'h7F; vals[4] = 8'hFE;
    x = '0; in_valid = 1'b0; rst = 1'b1;

    // Reset state
    cycle(8'h5A, 1'b1, 1'b1);
    cycle(8'h00, 1'b0, 1'b1);
    check("rst_state", {30'd0, zero_q, one_q}, 32'd0);

    // Combinational decode, no clock edge relied on
    for (int i = 0; i < 5; i++) begin
      x = vals[i];
      #10;
      check_comb(vals[i]);
    end

    // Three zeros, then one all-ones word
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b1, 1'b0);
    check("zero_run3", {24'd0, zero_run}, 32'd3);
    cycle(8'hFF, 1'b1, 1'b0);
    check("one_run1", {24'd0, one_run}, 32'd1);
    check("zero_run_clr", {24'd0, zero_run}, 32'd0);

    // Saturation
    for (int i = 0; i < 300; i++) cycle(8'h00, 1'b1, 1'b0);
    check("zero_sat", {24'd0, zero_run}, CNT_MAX);

    // Mid-run reset, then idle hold
    cycle(8'h00, 1'b1, 1'b1);
    check("mid_rst", {14'd0, zero_q, one_q, zero_run, one_run}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(8'hFF, 1'b0, 1'b0);
    cycle(8'hFF, 1'b1, 1'b0);
    check("restart_run", {24'd0, one_run}, 32'd1);
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0, 1'b0);

    // Random traffic, biased towards runs of uniform words
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0: xr = 8'h00;
        1: xr = 8'hFF;
        default: xr = WIDTH'($urandom);
      endcase
      cycle(xr, ($urandom_range(0, 7) != 0), ($urandom_range(0, 99) == 0));
      check_comb(xr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
